// File: rtl/cga_pkg.sv
// Shared encodings and default sizes for the Cartesian GA controller and its sort stage.
package cga_pkg;

  localparam logic [2:0] CTRL_SORT = 3'b010;

  typedef enum logic [3:0] {
    IDLE_sortFSM      = 4'b0000,
    LOAD_sortFSM      = 4'b0001,
    LOAD_LAST_sortFSM = 4'b0010,
    COMPARE_sortFSM   = 4'b0011,
    PASS_END_sortFSM  = 4'b0100,
    finished_sortFSM  = 4'b1000
  } sort_state_e;

  localparam int POP_SIZE_DEF = 8;
  localparam int FIT_W_DEF    = 8;
  localparam int IDX_W_DEF    = 3;

endpackage

// File: rtl/cga_cmp_swap.sv
// Compare-and-swap cell: orders two {fitness, index} pairs so the fitter one comes first.
// Ties keep the incoming order, which keeps the bubble sort stable.
module cga_cmp_swap #(
  parameter int FIT_W = 8,
  parameter int IDX_W = 3
) (
  input  logic [FIT_W-1:0] i_a_fit,
  input  logic [IDX_W-1:0] i_a_idx,
  input  logic [FIT_W-1:0] i_b_fit,
  input  logic [IDX_W-1:0] i_b_idx,
  output logic [FIT_W-1:0] o_first_fit,
  output logic [IDX_W-1:0] o_first_idx,
  output logic [FIT_W-1:0] o_second_fit,
  output logic [IDX_W-1:0] o_second_idx,
  output logic             o_swap
);

  logic w_swap;

  assign w_swap       = (i_b_fit > i_a_fit);
  assign o_swap       = w_swap;
  assign o_first_fit  = w_swap ? i_b_fit : i_a_fit;
  assign o_first_idx  = w_swap ? i_b_idx : i_a_idx;
  assign o_second_fit = w_swap ? i_a_fit : i_b_fit;
  assign o_second_idx = w_swap ? i_a_idx : i_b_idx;

endmodule

// File: rtl/cga_sort_fsm.sv
// Population sorter: loads fitness, bubble-sorts descending into a rank table.
// Build option SORT_EARLY_EXIT_EN ends the sort after the first pass without swaps.
module cga_sort_fsm
  import cga_pkg::*;
#(
  parameter int POP_SIZE = POP_SIZE_DEF,
  parameter int FIT_W    = FIT_W_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [2:0]       state_controller,
  output logic             fit_rd_en,
  output logic [IDX_W-1:0] fit_addr,
  input  logic [FIT_W-1:0] fit_data,
  input  logic [IDX_W-1:0] rank_addr,
  output logic [IDX_W-1:0] rank_idx,
  output logic [IDX_W-1:0] best_idx,
  output logic [FIT_W-1:0] best_fitness,
  output logic [3:0]       state_sortFSM
);

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(POP_SIZE - 1);
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(POP_SIZE - 2);
  localparam logic [IDX_W-1:0] P_LAST = IDX_W'(POP_SIZE - 2);

  sort_state_e      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_k, r_j, r_p;
  logic             r_swapped;
  logic [FIT_W-1:0] r_fit [POP_SIZE];
  logic [IDX_W-1:0] r_idx [POP_SIZE];
  logic [IDX_W-1:0] r_best_idx;
  logic [FIT_W-1:0] r_best_fit;

  logic             w_go, w_last_pass, w_swap;
  logic [IDX_W-1:0] w_j1, w_km1;
  logic [FIT_W-1:0] w_first_fit, w_second_fit;
  logic [IDX_W-1:0] w_first_idx, w_second_idx;

  assign w_go  = (state_controller == CTRL_SORT);
  assign w_j1  = r_j + IDX_W'(1);
  assign w_km1 = r_k - IDX_W'(1);

`ifdef SORT_EARLY_EXIT_EN
  assign w_last_pass = (r_p == P_LAST) || !r_swapped;
`else
  assign w_last_pass = (r_p == P_LAST);
`endif

  cga_cmp_swap #(.FIT_W(FIT_W), .IDX_W(IDX_W)) u_cmp_swap (
    .i_a_fit      (r_fit[r_j]),
    .i_a_idx      (r_idx[r_j]),
    .i_b_fit      (r_fit[w_j1]),
    .i_b_idx      (r_idx[w_j1]),
    .o_first_fit  (w_first_fit),
    .o_first_idx  (w_first_idx),
    .o_second_fit (w_second_fit),
    .o_second_idx (w_second_idx),
    .o_swap       (w_swap)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE_sortFSM;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE_sortFSM:      if (w_go) w_state_nxt = LOAD_sortFSM;
      LOAD_sortFSM:      if (!w_go) w_state_nxt = IDLE_sortFSM;
                         else if (r_k == K_LAST) w_state_nxt = LOAD_LAST_sortFSM;
      LOAD_LAST_sortFSM: w_state_nxt = w_go ? COMPARE_sortFSM : IDLE_sortFSM;
      COMPARE_sortFSM:   if (!w_go) w_state_nxt = IDLE_sortFSM;
                         else if (r_j == J_LAST) w_state_nxt = PASS_END_sortFSM;
      PASS_END_sortFSM:  if (!w_go) w_state_nxt = IDLE_sortFSM;
                         else w_state_nxt = w_last_pass ? finished_sortFSM : COMPARE_sortFSM;
      finished_sortFSM:  if (!w_go) w_state_nxt = IDLE_sortFSM;
      default:           w_state_nxt = IDLE_sortFSM;
    endcase
  end

  // Rank table is re-initialised only when a new sort starts, so it survives the return to IDLE.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_k        <= '0;
      r_j        <= '0;
      r_p        <= '0;
      r_swapped  <= 1'b0;
      r_best_idx <= '0;
      r_best_fit <= '0;
      for (int i = 0; i < POP_SIZE; i++) begin
        r_fit[i] <= '0;
        r_idx[i] <= IDX_W'(i);
      end
    end else begin
      case (r_state)
        IDLE_sortFSM: begin
          r_k       <= '0;
          r_j       <= '0;
          r_p       <= '0;
          r_swapped <= 1'b0;
          if (w_go) begin
            for (int i = 0; i < POP_SIZE; i++) r_idx[i] <= IDX_W'(i);
          end
        end
        LOAD_sortFSM: if (w_go) begin
          r_k <= r_k + IDX_W'(1);
          if (r_k != '0) r_fit[w_km1] <= fit_data;
        end
        LOAD_LAST_sortFSM: if (w_go) begin
          r_fit[POP_SIZE-1] <= fit_data;
          r_swapped         <= 1'b0;
          r_j               <= '0;
        end
        COMPARE_sortFSM: if (w_go) begin
          r_fit[r_j]  <= w_first_fit;
          r_idx[r_j]  <= w_first_idx;
          r_fit[w_j1] <= w_second_fit;
          r_idx[w_j1] <= w_second_idx;
          if (w_swap) r_swapped <= 1'b1;
          r_j <= w_j1;
        end
        PASS_END_sortFSM: if (w_go) begin
          r_p       <= r_p + IDX_W'(1);
          r_j       <= '0;
          r_swapped <= 1'b0;
          if (w_last_pass) begin
            r_best_idx <= r_idx[0];
            r_best_fit <= r_fit[0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rank_idx = '0;
    if (32'(rank_addr) < POP_SIZE) rank_idx = r_idx[rank_addr];
  end

  assign fit_rd_en     = (r_state == LOAD_sortFSM) && w_go;
  assign fit_addr      = (r_state == LOAD_sortFSM) ? r_k : '0;
  assign best_idx      = r_best_idx;
  assign best_fitness  = r_best_fit;
  assign state_sortFSM = r_state;

endmodule

// File: tb/tb_cga_sort_fsm.sv
// Directed/randomized bench for cga_sort_fsm against a stable selection-sort reference.
module tb_cga_sort_fsm;
  import cga_pkg::*;

  localparam int N  = 8;
  localparam int FW = 8;
  localparam int IW = 3;

  logic          CLOCK_50 = 1'b0;
  logic          reset_n  = 1'b0;
  logic [2:0]    state_controller = 3'b000;
  logic          fit_rd_en;
  logic [IW-1:0] fit_addr;
  logic [FW-1:0] fit_data = '0;
  logic [IW-1:0] rank_addr = '0;
  logic [IW-1:0] rank_idx;
  logic [IW-1:0] best_idx;
  logic [FW-1:0] best_fitness;
  logic [3:0]    state_sortFSM;

  cga_sort_fsm #(.POP_SIZE(N), .FIT_W(FW), .IDX_W(IW)) dut (
    .CLOCK_50         (CLOCK_50),
    .reset_n          (reset_n),
    .state_controller (state_controller),
    .fit_rd_en        (fit_rd_en),
    .fit_addr         (fit_addr),
    .fit_data         (fit_data),
    .rank_addr        (rank_addr),
    .rank_idx         (rank_idx),
    .best_idx         (best_idx),
    .best_fitness     (best_fitness),
    .state_sortFSM    (state_sortFSM)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [FW-1:0] mem [N];
  int exp_rank [N];
  int exp_lat;
  int n_cmp = 0;
  int n_bad = 0;

  // Fitness memory: data appears one cycle after the read strobe.
  always @(posedge CLOCK_50) if (fit_rd_en) fit_data <= mem[fit_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: repeatedly pick the fittest remaining individual, lowest index on ties.
  task automatic build_model();
    bit used [N];
    int best, passes;
    int maxinv, cnt;
    for (int i = 0; i < N; i++) used[i] = 1'b0;
    for (int r = 0; r < N; r++) begin
      best = -1;
      for (int i = 0; i < N; i++)
        if (!used[i] && (best < 0 || mem[i] > mem[best])) best = i;
      exp_rank[r] = best;
      used[best]  = 1'b1;
    end
    maxinv = 0;
    for (int i = 0; i < N; i++) begin
      cnt = 0;
      for (int h = 0; h < i; h++) if (mem[h] < mem[i]) cnt++;
      if (cnt > maxinv) maxinv = cnt;
    end
`ifdef SORT_EARLY_EXIT_EN
    passes = (maxinv + 1 < N - 1) ? maxinv + 1 : N - 1;
`else
    passes = N - 1;
`endif
    exp_lat = (N + 1) + passes * N;
  endtask

  task automatic run_sort(input string tag);
    int cnt;
    build_model();
    @(negedge CLOCK_50);
    state_controller = CTRL_SORT;
    @(negedge CLOCK_50);
    chk({tag, ".load0_state"}, 32'(state_sortFSM), 32'(LOAD_sortFSM));
    chk({tag, ".load0_addr"}, 32'(fit_addr), 32'd0);
    cnt = 0;
    while (state_sortFSM !== finished_sortFSM && cnt < 400) begin
      @(negedge CLOCK_50);
      cnt++;
    end
    chk({tag, ".latency"}, 32'(cnt), 32'(exp_lat));
    chk({tag, ".best_idx"}, 32'(best_idx), 32'(exp_rank[0]));
    chk({tag, ".best_fit"}, 32'(best_fitness), 32'(mem[exp_rank[0]]));
    for (int r = 0; r < N; r++) begin
      rank_addr = IW'(r);
      #1;
      chk($sformatf("%s.rank%0d", tag, r), 32'(rank_idx), 32'(exp_rank[r]));
    end
  endtask

  task automatic leave_sort(input string tag);
    @(negedge CLOCK_50);
    state_controller = 3'b011;
    @(negedge CLOCK_50);
    chk({tag, ".to_idle"}, 32'(state_sortFSM), 32'(IDLE_sortFSM));
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = FW'($urandom_range(0, 15));
  endtask

  initial begin
    int cnt;

    #3;
    chk("rst.state", 32'(state_sortFSM), 32'(IDLE_sortFSM));
    chk("rst.rd_en", 32'(fit_rd_en), 32'd0);
    chk("rst.addr", 32'(fit_addr), 32'd0);
    chk("rst.best_idx", 32'(best_idx), 32'd0);
    chk("rst.best_fit", 32'(best_fitness), 32'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;

    mem = '{8'd3, 8'd7, 8'd1, 8'd7, 8'd0, 8'd5, 8'd2, 8'd6};
    run_sort("mixed");
    chk("mixed.best_idx_const", 32'(best_idx), 32'd1);
    chk("mixed.best_fit_const", 32'(best_fitness), 32'd7);

    repeat (20) @(negedge CLOCK_50);
    chk("hold.state", 32'(state_sortFSM), 32'(finished_sortFSM));
    leave_sort("hold");

    mem = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    run_sort("presorted");
    leave_sort("presorted");

    for (int i = 0; i < N; i++) mem[i] = 8'd4;
    run_sort("ties");
    leave_sort("ties");

    fill_random();
    @(negedge CLOCK_50);
    state_controller = CTRL_SORT;
    cnt = 0;
    while (!(state_sortFSM === LOAD_sortFSM && fit_addr === 3'd3) && cnt < 50) begin
      @(negedge CLOCK_50);
      cnt++;
    end
    chk("abort.reach_k3", 32'(fit_addr), 32'd3);
    state_controller = 3'b000;
    @(negedge CLOCK_50);
    chk("abort.state", 32'(state_sortFSM), 32'(IDLE_sortFSM));
    chk("abort.rd_en", 32'(fit_rd_en), 32'd0);
    run_sort("after_abort");
    leave_sort("after_abort");

    for (int t = 0; t < 5; t++) begin
      fill_random();
      run_sort($sformatf("rand%0d", t));
      leave_sort($sformatf("rand%0d", t));
    end

    fill_random();
    @(negedge CLOCK_50);
    state_controller = CTRL_SORT;
    cnt = 0;
    while (state_sortFSM !== COMPARE_sortFSM && cnt < 50) begin
      @(negedge CLOCK_50);
      cnt++;
    end
    chk("midrst.reach_cmp", 32'(state_sortFSM), 32'(COMPARE_sortFSM));
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst.state", 32'(state_sortFSM), 32'(IDLE_sortFSM));
    chk("midrst.rd_en", 32'(fit_rd_en), 32'd0);
    state_controller = 3'b000;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    for (int r = 0; r < N; r++) begin
      @(negedge CLOCK_50);
      rank_addr = IW'(r);
      #1;
      chk($sformatf("midrst.idx%0d", r), 32'(rank_idx), 32'(r));
    end
    chk("midrst.best_idx", 32'(best_idx), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
